// File: rtl/rect_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rect_overlay_ctrl
// Description : Rectangle overlay engine with shadowed, frame-synchronous
//               descriptor commit and lowest-index-wins pixel colouring.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_overlay_ctrl #(
    parameter int          N_RECT   = 4,
    parameter logic [11:0] BG_COLOR = 12'h000,
    localparam int         IDX_W    = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_stb,
    input  logic [9:0]       i_x,
    input  logic [8:0]       i_y,
    input  logic             i_frame_stb,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [IDX_W-1:0] i_cfg_idx,
    input  logic [2:0]       i_cfg_field,
    input  logic [11:0]      i_cfg_data,
    output logic             o_cfg_err,
    output logic             o_commit_done,
    output logic             o_pending,
    output logic [11:0]      o_rgb,
    output logic             o_hit,
    output logic [15:0]      o_frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_cfg_ready;
    logic         w_commit_done;
    logic         w_pending;
    logic         w_accept;
    logic         r_cfg_err;
    logic [11:0]  r_rgb;
    logic         r_hit;
    logic [15:0]  r_frame_cnt;

    // Priority chain: element k holds the result for rectangles k..N_RECT-1
    logic [11:0]  w_chain_col [N_RECT+1];
    logic         w_chain_hit [N_RECT+1];

    assign w_accept = i_cfg_valid & w_cfg_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cfg_ready   = 1'b1;
        w_commit_done = 1'b0;
        w_pending     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (i_cfg_field == 3'd6)) begin
                    w_state_nxt = S_PENDING;
                end
            end
            S_PENDING: begin
                w_pending = 1'b1;
                if (i_frame_stb) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_pending     = 1'b1;
                w_cfg_ready   = 1'b0;
                w_commit_done = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_chain_col[N_RECT] = BG_COLOR;
    assign w_chain_hit[N_RECT] = 1'b0;

    for (genvar k = 0; k < N_RECT; k++) begin : g_rect
        localparam logic [IDX_W-1:0] c_IDX = IDX_W'(k);

        logic [9:0]  r_sh_x0, r_sh_x1, r_act_x0, r_act_x1;
        logic [8:0]  r_sh_y0, r_sh_y1, r_act_y0, r_act_y1;
        logic [11:0] r_sh_col, r_act_col;
        logic        r_sh_en, r_act_en;
        logic        w_wr;
        logic        w_hit;

        assign w_wr = w_accept & (i_cfg_idx == c_IDX);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sh_x0  <= '0;
                r_sh_y0  <= '0;
                r_sh_x1  <= '0;
                r_sh_y1  <= '0;
                r_sh_col <= '0;
                r_sh_en  <= 1'b0;
            end else if (w_wr) begin
                case (i_cfg_field)
                    3'd0:    r_sh_x0  <= i_cfg_data[9:0];
                    3'd1:    r_sh_y0  <= i_cfg_data[8:0];
                    3'd2:    r_sh_x1  <= i_cfg_data[9:0];
                    3'd3:    r_sh_y1  <= i_cfg_data[8:0];
                    3'd4:    r_sh_col <= i_cfg_data;
                    3'd5:    r_sh_en  <= i_cfg_data[0];
                    default: ;
                endcase
            end
        end

        // Active set only changes on the edge leaving COMMIT (vertical blanking)
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_act_x0  <= '0;
                r_act_y0  <= '0;
                r_act_x1  <= '0;
                r_act_y1  <= '0;
                r_act_col <= '0;
                r_act_en  <= 1'b0;
            end else if (r_state == S_COMMIT) begin
                r_act_x0  <= r_sh_x0;
                r_act_y0  <= r_sh_y0;
                r_act_x1  <= r_sh_x1;
                r_act_y1  <= r_sh_y1;
                r_act_col <= r_sh_col;
                r_act_en  <= r_sh_en;
            end
        end

        // Strict compares make degenerate rectangles (x0>=x1 or y0>=y1) never hit
        assign w_hit = r_act_en
                     & (i_x > r_act_x0) & (i_x < r_act_x1)
                     & (i_y > r_act_y0) & (i_y < r_act_y1);

        assign w_chain_hit[k] = w_hit | w_chain_hit[k+1];
        assign w_chain_col[k] = w_hit ? r_act_col : w_chain_col[k+1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb       <= BG_COLOR;
            r_hit       <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_cfg_err <= w_accept & (i_cfg_field == 3'd7);
            if (i_pix_stb) begin
                r_rgb <= w_chain_col[0];
                r_hit <= w_chain_hit[0];
            end
            if (i_frame_stb) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign o_cfg_ready   = w_cfg_ready;
    assign o_commit_done = w_commit_done;
    assign o_pending     = w_pending;
    assign o_cfg_err     = r_cfg_err;
    assign o_rgb         = r_rgb;
    assign o_hit         = r_hit;
    assign o_frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rect_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rect_overlay_ctrl
// Description : Scoreboard bench for rect_overlay_ctrl (3 rectangles, so an
//               out-of-range index can be exercised).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_overlay_ctrl;

    localparam int          N  = 3;
    localparam logic [11:0] BG = 12'h000;

    typedef struct {
        logic [9:0]  x0;
        logic [8:0]  y0;
        logic [9:0]  x1;
        logic [8:0]  y1;
        logic [11:0] col;
        logic        en;
    } rect_t;

    typedef struct {
        int          x;
        int          y;
        logic [12:0] v;
    } pent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_stb = 1'b0;
    logic [9:0]  px = '0;
    logic [8:0]  py = '0;
    logic        frame_stb = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_idx = '0;
    logic [2:0]  cfg_field = '0;
    logic [11:0] cfg_data = '0;
    logic        cfg_err;
    logic        commit_done;
    logic        pending;
    logic [11:0] rgb;
    logic        hit;
    logic [15:0] frame_cnt;

    rect_t sh [N];
    rect_t act [N];
    int    m_frames = 0;
    pent_t exp_q [$];
    pent_t obs_q [$];
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    rect_overlay_ctrl #(.N_RECT(N), .BG_COLOR(BG)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_stb     (pix_stb),
        .i_x           (px),
        .i_y           (py),
        .i_frame_stb   (frame_stb),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (cfg_ready),
        .i_cfg_idx     (cfg_idx),
        .i_cfg_field   (cfg_field),
        .i_cfg_data    (cfg_data),
        .o_cfg_err     (cfg_err),
        .o_commit_done (commit_done),
        .o_pending     (pending),
        .o_rgb         (rgb),
        .o_hit         (hit),
        .o_frame_cnt   (frame_cnt)
    );

    function automatic logic [12:0] model_pix(input logic [9:0] x, input logic [8:0] y);
        for (int k = 0; k < N; k++) begin
            if (act[k].en && x > act[k].x0 && x < act[k].x1 && y > act[k].y0 && y < act[k].y1)
                return {1'b1, act[k].col};
        end
        return {1'b0, BG};
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N; k++) begin
            sh[k]  = '{x0: '0, y0: '0, x1: '0, y1: '0, col: '0, en: 1'b0};
            act[k] = '{x0: '0, y0: '0, x1: '0, y1: '0, col: '0, en: 1'b0};
        end
        m_frames = 0;
    endfunction

    function automatic void model_commit();
        for (int k = 0; k < N; k++) act[k] = sh[k];
    endfunction

    task automatic cfg_write(input int idx, input int field, input logic [11:0] data);
        bit ok = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_idx   = idx[1:0];
        cfg_field = field[2:0];
        cfg_data  = data;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (cfg_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        cfg_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL cfg_write_timeout: ready stayed %0b, required 1 (idx=%0d field=%0d)", cfg_ready, idx, field);
        end else if (idx < N) begin
            case (field)
                0: sh[idx].x0  = data[9:0];
                1: sh[idx].y0  = data[8:0];
                2: sh[idx].x1  = data[9:0];
                3: sh[idx].y1  = data[8:0];
                4: sh[idx].col = data;
                5: sh[idx].en  = data[0];
                default: ;
            endcase
        end
    endtask

    task automatic write_rect(input int idx, input int x0, input int y0, input int x1,
                              input int y1, input logic [11:0] col, input bit en);
        cfg_write(idx, 0, 12'(x0));
        cfg_write(idx, 1, 12'(y0));
        cfg_write(idx, 2, 12'(x1));
        cfg_write(idx, 3, 12'(y1));
        cfg_write(idx, 4, col);
        cfg_write(idx, 5, {11'd0, en});
    endtask

    task automatic pix(input int x, input int y);
        pent_t e;
        pent_t a;
        @(negedge clk);
        px = x[9:0];
        py = y[8:0];
        pix_stb = 1'b1;
        e.x = x; e.y = y; e.v = model_pix(px, py);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a.x = x; a.y = y; a.v = {hit, rgb};
        obs_q.push_back(a);
        pix_stb = 1'b0;
    endtask

    task automatic frame(output int done_cnt);
        @(negedge clk);
        frame_stb = 1'b1;
        pix_stb   = 1'b1;
        px = 10'd0;
        py = 9'd480;
        @(posedge clk);
        #1;
        frame_stb = 1'b0;
        pix_stb   = 1'b0;
        m_frames++;
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (commit_done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        int d;
        pent_t e, a;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cfg_ready, cfg_err, commit_done, pending, hit, rgb, frame_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BG, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%0b err=%0b done=%0b pend=%0b hit=%0b rgb=%h cnt=%0d, expected 1 0 0 0 0 %h 0",
                     cfg_ready, cfg_err, commit_done, pending, hit, rgb, frame_cnt, BG);
        end
        for (int y = 0; y < 480; y += 40)
            for (int x = 0; x < 640; x += 40)
                pix(x, y);
        frame(d);
        frame(d);
        n_checks++;
        if (frame_cnt !== 16'(m_frames) || d !== 0) begin
            n_fail++;
            $display("FAIL reset_frames: got cnt=%0d done=%0d, expected cnt=%0d done=0", frame_cnt, d, m_frames);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
            if (a.v !== e.v) begin
                n_fail++;
                $display("FAIL reset_pix(%0d,%0d): got %h, expected %h", e.x, e.y, a.v, e.v);
            end
        end
    endtask

    task automatic test_single_rect();
        int d;
        pent_t e, a;
        write_rect(0, 260, 40, 380, 440, 12'hF8F, 1'b1);
        cfg_write(0, 6, 12'h000);
        @(negedge clk);
        n_checks++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pending: got %0b, expected 1", pending);
        end
        frame(d);
        model_commit();
        n_checks++;
        if (d !== 1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL single_commit: got done_cycles=%0d pend=%0b, expected 1 and 0", d, pending);
        end
        pix(300, 100); pix(260, 100); pix(379, 439); pix(380, 100); pix(300, 40);
        n_checks++;
        if (exp_q[0].v !== {1'b1, 12'hF8F}) begin
            n_fail++;
            $display("FAIL single_model_ref: got %h, expected %h", exp_q[0].v, {1'b1, 12'hF8F});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
            if (a.v !== e.v) begin
                n_fail++;
                $display("FAIL single_pix(%0d,%0d): got %h, expected %h", e.x, e.y, a.v, e.v);
            end
        end
    endtask

    task automatic test_no_commit();
        int d1, d2;
        pent_t e, a;
        cfg_write(0, 4, 12'h0F0);
        frame(d1);
        frame(d2);
        n_checks++;
        if (d1 + d2 !== 0 || frame_cnt !== 16'(m_frames)) begin
            n_fail++;
            $display("FAIL nocommit_frames: got done=%0d cnt=%0d, expected 0 and %0d", d1 + d2, frame_cnt, m_frames);
        end
        pix(300, 100);
        cfg_write(0, 6, 12'h000);
        cfg_write(0, 2, 12'd320);
        cfg_write(0, 6, 12'h000);
        pix(300, 100);
        frame(d1);
        model_commit();
        frame(d2);
        n_checks++;
        if (d1 !== 1 || d2 !== 0) begin
            n_fail++;
            $display("FAIL nocommit_single_commit: got done=%0d then %0d, expected 1 then 0", d1, d2);
        end
        pix(300, 100); pix(330, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
            if (a.v !== e.v) begin
                n_fail++;
                $display("FAIL nocommit_pix(%0d,%0d): got %h, expected %h", e.x, e.y, a.v, e.v);
            end
        end
    endtask

    task automatic test_priority();
        int d;
        pent_t e, a;
        write_rect(0, 120, 180, 520, 300, 12'hF00, 1'b1);
        write_rect(1, 260, 40, 380, 440, 12'h00F, 1'b1);
        write_rect(2, 400, 0, 400, 479, 12'hFFF, 1'b1);
        write_rect(3, 0, 0, 639, 479, 12'hABC, 1'b1);
        cfg_write(0, 6, 12'h000);
        frame(d);
        model_commit();
        n_checks++;
        if (d !== 1) begin
            n_fail++;
            $display("FAIL prio_commit: got done=%0d, expected 1", d);
        end
        pix(300, 200); pix(300, 100); pix(150, 100); pix(400, 100);
        pix(400, 200); pix(520, 200); pix(519, 299);
        for (int y = 20; y < 480; y += 40)
            for (int x = 20; x < 640; x += 40)
                pix(x, y);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
            if (a.v !== e.v) begin
                n_fail++;
                $display("FAIL prio_pix(%0d,%0d): got %h, expected %h", e.x, e.y, a.v, e.v);
            end
        end
    endtask

    task automatic test_commit_backpressure();
        int d;
        pent_t e, a;
        cfg_write(1, 6, 12'h000);
        @(negedge clk);
        frame_stb = 1'b1;
        pix_stb   = 1'b1;
        px = 10'd0;
        py = 9'd480;
        @(posedge clk);
        #1;
        frame_stb = 1'b0;
        pix_stb   = 1'b0;
        m_frames++;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_idx   = 2'd1;
        cfg_field = 3'd0;
        cfg_data  = 12'd300;
        n_checks++;
        if ({cfg_ready, commit_done, pending} !== 3'b011) begin
            n_fail++;
            $display("FAIL bp_commit_cycle: got ready=%0b done=%0b pend=%0b, expected 0 1 1", cfg_ready, commit_done, pending);
        end
        @(posedge clk);
        #1;
        model_commit();
        @(negedge clk);
        n_checks++;
        if ({cfg_ready, commit_done, pending} !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_after_commit: got ready=%0b done=%0b pend=%0b, expected 1 0 0", cfg_ready, commit_done, pending);
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        sh[1].x0 = 10'd300;
        pix(300, 100);
        cfg_write(1, 6, 12'h000);
        frame(d);
        model_commit();
        n_checks++;
        if (d !== 1) begin
            n_fail++;
            $display("FAIL bp_second_commit: got done=%0d, expected 1", d);
        end
        pix(300, 100); pix(320, 100);
        cfg_write(0, 7, 12'h123);
        n_checks++;
        if (cfg_err !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse: got err=%0b pend=%0b, expected 1 and 0", cfg_err, pending);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_width: got err=%0b, expected 0", cfg_err);
        end
        pix(320, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
            if (a.v !== e.v) begin
                n_fail++;
                $display("FAIL bp_pix(%0d,%0d): got %h, expected %h", e.x, e.y, a.v, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        int d;
        pent_t e, a;
        write_rect(2, 0, 0, 639, 479, 12'h555, 1'b1);
        cfg_write(2, 6, 12'h000);
        pix(320, 100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if ({cfg_ready, cfg_err, commit_done, pending, hit, rgb, frame_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BG, 16'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got ready=%0b err=%0b done=%0b pend=%0b hit=%0b rgb=%h cnt=%0d, expected 1 0 0 0 0 %h 0",
                     cfg_ready, cfg_err, commit_done, pending, hit, rgb, frame_cnt, BG);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame(d);
        n_checks++;
        if (d !== 0 || frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_discard: got done=%0d cnt=%0d, expected 0 and 1", d, frame_cnt);
        end
        pix(300, 100); pix(10, 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
            if (a.v !== e.v) begin
                n_fail++;
                $display("FAIL rstmid_pix(%0d,%0d): got %h, expected %h", e.x, e.y, a.v, e.v);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_rect();
        test_no_commit();
        test_priority();
        test_commit_backpressure();
        test_reset_mid_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rect_overlay_ctrl.md
Name: rect_overlay_ctrl

Overview:
Configurable rectangle overlay engine placed between vga640x480 and the VGA colour pins. It holds N_RECT rectangle descriptors in shadow registers, which a host writes through a valid/ready port. Shadow registers are committed to the active set only at the start of vertical blanking, so updates are tear-free. Per pixel strobe it resolves priority between overlapping rectangles and drives a registered 12-bit RGB value.

Parameters:
N_RECT, 4, number of rectangle descriptors (index width = clog2(N_RECT), min 1)
BG_COLOR, 12'h000, colour driven when no enabled rectangle covers the pixel

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_pix_stb  in  1  pixel strobe, one i_clk cycle per pixel
i_x  in  10  current pixel x from timing generator
i_y  in  9  current pixel y from timing generator
i_frame_stb  in  1  one-cycle pulse at start of vertical blanking, coincident with i_pix_stb
i_cfg_valid  in  1  config write request
o_cfg_ready  out  1  config write accept
i_cfg_idx  in  clog2(N_RECT)  rectangle index
i_cfg_field  in  3  0=x0, 1=y0, 2=x1, 3=y1, 4=colour, 5=enable(bit0), 6=commit request, 7=reserved
i_cfg_data  in  12  field value; x uses [9:0], y uses [8:0]
o_cfg_err  out  1  one-cycle pulse: field 7 written
o_commit_done  out  1  one-cycle pulse in the commit cycle
o_pending  out  1  commit requested, not yet applied
o_rgb  out  12  {R[3:0],G[3:0],B[3:0]} registered pixel colour
o_hit  out  1  registered: some enabled rectangle covers the pixel
o_frame_cnt  out  16  frames elapsed; increments on each i_frame_stb, wraps at 0xFFFF->0

Behaviour:
- Reset (async, i_rst_n=0): all shadow and active descriptors = 0, enables = 0; state IDLE; o_cfg_ready=1; o_cfg_err=0; o_commit_done=0; o_pending=0; o_rgb=BG_COLOR; o_hit=0; o_frame_cnt=0. Reset during PENDING or COMMIT discards the commit; the active set is cleared.
- Write handshake: a transfer occurs on the rising edge where i_cfg_valid & o_cfg_ready. Fields 0-5 update the shadow register at that edge; upper data bits are truncated. Index >= N_RECT is accepted and ignored. Field 7 is accepted, ignored, and o_cfg_err is asserted the next cycle.
- FSM states IDLE, PENDING, COMMIT:
  - IDLE -> PENDING on an accepted field-6 write.
  - PENDING -> COMMIT on the edge where i_frame_stb=1.
  - COMMIT -> IDLE after exactly one cycle.
  - Field-6 write in PENDING: stays PENDING with no double commit.
  - Field-6 write accepted on the same edge as i_frame_stb in IDLE: goes to PENDING only, so the commit is applied at the next frame.
- o_pending=1 in PENDING and COMMIT. o_cfg_ready=0 only in COMMIT; a host holding valid through COMMIT completes its write on the following cycle.
- Shadow writes in PENDING are allowed and are included in the pending commit.
- COMMIT cycle: o_commit_done=1. All active descriptors load from shadow at the edge leaving COMMIT. The shadow set is unchanged.
- Pixel path, evaluated only when i_pix_stb=1, using the active set:
  - Rectangle k hits when en_k & (i_x > x0_k) & (i_x < x1_k) & (i_y > y0_k) & (i_y < y1_k). Comparisons are strict and unsigned.
  - If x0 >= x1 or y0 >= y1, the rectangle never hits.
  - Priority: the lowest index hit wins, and o_rgb = colour of the winner. With no hit, o_rgb = BG_COLOR and o_hit=0.
  - Latency: o_rgb and o_hit update at the i_clk edge where i_pix_stb=1 and hold otherwise. One pixel strobe of latency relative to i_x/i_y.
- Priority logic is a purely combinational chain over N_RECT feeding a single output register. No multicycle paths.

Test Plan:
- Reset release, no writes, sweep full frame -> o_rgb=12'h000 and o_hit=0 for every pixel; o_cfg_ready=1; o_frame_cnt increments once per i_frame_stb.
- Write rect0 {x0=260,y0=40,x1=380,y1=440,col=12'hF8F,en=1}, then commit, then frame_stb -> o_commit_done pulse one cycle. In the next frame (x=300,y=100) gives 12'hF8F; (x=260,y=100) gives BG due to strict compare.
- Write rect0 without commit, then two frame_stb -> output unchanged (all BG). Write commit -> applied at the next frame_stb only.
- Rect0 {120,180,520,300,12'hF00} and rect1 {260,40,380,440,12'h00F}, both enabled -> (300,200) gives 12'hF00 (index 0 wins); (300,100) gives 12'h00F; (150,100) gives BG.
- Hold i_cfg_valid high with a field-0 write across the COMMIT cycle -> o_cfg_ready=0 for exactly one cycle; the write lands the cycle after and is excluded from that commit. Field-7 write -> o_cfg_err pulse, no state change.
- Assert i_rst_n=0 mid-PENDING after rect writes -> all outputs return to reset values asynchronously; after release, frame_stb produces no commit.
